// File: rtl/btb_tag_array_if.sv
// rtl/btb_tag_array_if.sv - lookup, update and flush signals of the BTB tag array
interface btb_tag_array_if;
    logic [15:0] lookup_pc;
    logic        lookup_valid;
    logic        comp0_out;
    logic        comp1_out;
    logic        comp2_out;
    logic        comp3_out;
    logic [15:0] target0;
    logic [15:0] target1;
    logic [15:0] target2;
    logic [15:0] target3;
    logic        hit;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        flush;

    modport master (
        output lookup_pc, lookup_valid, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  comp0_out, comp1_out, comp2_out, comp3_out,
        input  target0, target1, target2, target3, hit
    );

    modport slave (
        input  lookup_pc, lookup_valid, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output comp0_out, comp1_out, comp2_out, comp3_out,
        output target0, target1, target2, target3, hit
    );
endinterface

// File: rtl/btb_tag_array.sv
// rtl/btb_tag_array.sv - 4-way set-associative BTB storage with tree pseudo-LRU
module btb_tag_array #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 16 - INDEX_BITS - 1
) (
    input  logic           clk,
    input  logic           reset,
    btb_tag_array_if.slave bus
);
    localparam int SETS = 2 ** INDEX_BITS;

    logic [3:0]          valid_q  [SETS];
    logic [3:0]          valid_d  [SETS];
    logic [2:0]          plru_q   [SETS];
    logic [2:0]          plru_d   [SETS];
    logic [TAG_BITS-1:0] tag_q    [SETS][4];
    logic [TAG_BITS-1:0] tag_d    [SETS][4];
    logic [15:0]         target_q [SETS][4];
    logic [15:0]         target_d [SETS][4];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic [3:0]            lk_match;
    logic [1:0]            lk_way;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic [3:0]            up_match;
    logic [1:0]            up_way;
    logic [1:0]            alloc_way;

    // plru bits are {b2,b1,b0}; a touch points the tree away from the touched way
    function automatic logic [2:0] touch(input logic [2:0] p, input logic [1:0] w);
        logic [2:0] r;
        r = p;
        case (w)
            2'd0:    begin r[0] = 1'b1; r[1] = 1'b1; end
            2'd1:    begin r[0] = 1'b1; r[1] = 1'b0; end
            2'd2:    begin r[0] = 1'b0; r[2] = 1'b1; end
            default: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        if (m[1]) r = 2'd1;
        if (m[2]) r = 2'd2;
        if (m[3]) r = 2'd3;
        return r;
    endfunction

    assign lk_idx = bus.lookup_pc[INDEX_BITS:1];
    assign lk_tag = bus.lookup_pc[15:INDEX_BITS+1];
    assign up_idx = bus.upd_pc[INDEX_BITS:1];
    assign up_tag = bus.upd_pc[15:INDEX_BITS+1];

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
            up_match[w] = valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag);
        end
    end

    assign lk_way = enc(lk_match);
    assign up_way = enc(up_match);

    always_comb begin
        alloc_way = plru_q[up_idx][0] ? (plru_q[up_idx][2] ? 2'd3 : 2'd2)
                                      : (plru_q[up_idx][1] ? 2'd1 : 2'd0);
        for (int w = 3; w >= 0; w--) begin
            if (!valid_q[up_idx][w]) alloc_way = 2'(w);
        end
    end

    assign bus.comp0_out = lk_match[0];
    assign bus.comp1_out = lk_match[1];
    assign bus.comp2_out = lk_match[2];
    assign bus.comp3_out = lk_match[3];
    assign bus.hit       = |lk_match;
    assign bus.target0   = target_q[lk_idx][0];
    assign bus.target1   = target_q[lk_idx][1];
    assign bus.target2   = target_q[lk_idx][2];
    assign bus.target3   = target_q[lk_idx][3];

    // update touch is applied after the lookup touch so it wins on a shared set
    always_comb begin
        valid_d  = valid_q;
        plru_d   = plru_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (bus.lookup_valid && (|lk_match)) begin
            plru_d[lk_idx] = touch(plru_q[lk_idx], lk_way);
        end
        if (bus.upd_valid) begin
            if (|up_match) begin
                if (bus.upd_taken) begin
                    target_d[up_idx][up_way] = bus.upd_target;
                    plru_d[up_idx] = touch(plru_q[up_idx], up_way);
                end else begin
                    valid_d[up_idx][up_way] = 1'b0;
                end
            end else if (bus.upd_taken) begin
                valid_d[up_idx][alloc_way]  = 1'b1;
                tag_d[up_idx][alloc_way]    = up_tag;
                target_d[up_idx][alloc_way] = bus.upd_target;
                plru_d[up_idx] = touch(plru_q[up_idx], alloc_way);
            end
        end
        if (bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = 4'b0000;
                plru_d[s]  = 3'b000;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= 4'b0000;
                plru_q[s]  <= 3'b000;
            end
        end else begin
            valid_q <= valid_d;
            plru_q  <= plru_d;
        end
    end

    // payload needs no reset; an entry is only visible through its valid bit
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end
endmodule

// File: tb/tb_btb_tag_array.sv
// tb/tb_btb_tag_array.sv - directed self-checking bench for btb_tag_array
module tb_btb_tag_array;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    btb_tag_array_if bus ();

    btb_tag_array dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [15:0] pc, input logic taken, input logic [15:0] tgt);
        @(negedge clk);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        bus.upd_taken = 1'b0;
    endtask

    task automatic look(input logic [15:0] pc);
        bus.lookup_pc = pc;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.lookup_pc    = 16'h1234;
        bus.lookup_valid = 1'b0;
        bus.upd_valid    = 1'b0;
        bus.upd_pc       = 16'h0000;
        bus.upd_taken    = 1'b0;
        bus.upd_target   = 16'h0000;
        bus.flush        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("hit_in_reset", {15'd0, bus.hit}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        look(16'h1234);
        chk("comps_after_reset", {12'd0, bus.comp3_out, bus.comp2_out, bus.comp1_out, bus.comp0_out}, 16'd0);
        chk("hit_after_reset", {15'd0, bus.hit}, 16'd0);

        upd(16'h1234, 1'b1, 16'h2000);
        look(16'h1234);
        chk("first_alloc_comp0", {15'd0, bus.comp0_out}, 16'd1);
        chk("first_alloc_target0", bus.target0, 16'h2000);
        chk("first_alloc_hit", {15'd0, bus.hit}, 16'd1);

        upd(16'h2234, 1'b1, 16'h2100);
        upd(16'h3234, 1'b1, 16'h2200);
        upd(16'h4234, 1'b1, 16'h2300);
        look(16'h4234);
        chk("fill_way3", {12'd0, bus.comp3_out, bus.comp2_out, bus.comp1_out, bus.comp0_out}, 16'h0008);
        chk("fill_target3", bus.target3, 16'h2300);
        look(16'h3234);
        chk("fill_way2", {12'd0, bus.comp3_out, bus.comp2_out, bus.comp1_out, bus.comp0_out}, 16'h0004);

        // touching way0 moves the victim from way0 to way2
        @(negedge clk);
        bus.lookup_pc    = 16'h1234;
        bus.lookup_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.lookup_valid = 1'b0;
        upd(16'h5234, 1'b1, 16'h2400);
        look(16'h5234);
        chk("victim_way2", {12'd0, bus.comp3_out, bus.comp2_out, bus.comp1_out, bus.comp0_out}, 16'h0004);
        chk("victim_target2", bus.target2, 16'h2400);
        look(16'h3234);
        chk("evicted_miss", {15'd0, bus.hit}, 16'd0);
        look(16'h1234);
        chk("way0_kept", {12'd0, bus.comp3_out, bus.comp2_out, bus.comp1_out, bus.comp0_out}, 16'h0001);

        upd(16'h1234, 1'b1, 16'h3000);
        look(16'h1234);
        chk("retarget_t0", bus.target0, 16'h3000);
        chk("retarget_t1", bus.target1, 16'h2100);
        chk("retarget_t2", bus.target2, 16'h2400);
        chk("retarget_t3", bus.target3, 16'h2300);

        upd(16'h1234, 1'b0, 16'h0000);
        look(16'h1234);
        chk("nt_invalidate_comp0", {15'd0, bus.comp0_out}, 16'd0);
        chk("nt_invalidate_hit", {15'd0, bus.hit}, 16'd0);

        // realloc refills the lowest invalid way (way0), plru stays {1,1,1}
        upd(16'h1234, 1'b1, 16'h3100);
        @(negedge clk);
        bus.lookup_pc    = 16'h2234;
        bus.lookup_valid = 1'b1;
        bus.upd_valid    = 1'b1;
        bus.upd_pc       = 16'h1234;
        bus.upd_taken    = 1'b1;
        bus.upd_target   = 16'h3200;
        #1;
        chk("same_cycle_comp1", {15'd0, bus.comp1_out}, 16'd1);
        chk("same_cycle_old_t0", bus.target0, 16'h3100);
        @(posedge clk);
        #1;
        bus.upd_valid    = 1'b0;
        bus.upd_taken    = 1'b0;
        bus.lookup_valid = 1'b0;
        look(16'h1234);
        chk("same_cycle_new_t0", bus.target0, 16'h3200);
        // update touch wins: plru 111 -> victims way3, then way1
        upd(16'h6234, 1'b1, 16'h2500);
        look(16'h6234);
        chk("order_victim_way3", {12'd0, bus.comp3_out, bus.comp2_out, bus.comp1_out, bus.comp0_out}, 16'h0008);
        upd(16'h7234, 1'b1, 16'h2600);
        look(16'h7234);
        chk("order_victim_way1", {12'd0, bus.comp3_out, bus.comp2_out, bus.comp1_out, bus.comp0_out}, 16'h0002);
        chk("order_target1", bus.target1, 16'h2600);

        @(negedge clk);
        bus.flush = 1'b1;
        upd(16'h0002, 1'b1, 16'h1111);
        bus.flush = 1'b0;
        look(16'h0002);
        chk("flush_drops_upd", {15'd0, bus.hit}, 16'd0);
        look(16'h1234);
        chk("flush_clears_set2", {15'd0, bus.hit}, 16'd0);
        look(16'h5234);
        chk("flush_clears_way2", {15'd0, bus.hit}, 16'd0);

        upd(16'h1234, 1'b1, 16'h4000);
        look(16'h1234);
        chk("pre_reset_hit", {15'd0, bus.hit}, 16'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_hit", {15'd0, bus.hit}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        look(16'h1234);
        chk("post_reset_hit", {15'd0, bus.hit}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btb_tag_array.md
Name: btb_tag_array

Overview:
- 4-way set-associative branch target buffer storage for the LC-3b fetch stage.
- Holds valid/tag/target per way plus 3-bit tree pseudo-LRU per set.
- Lookup side: per-way tag-match strobes and way targets, combinationally from fetch PC, consumed by the BTB way encoder and target mux.
- Update side: writes, allocates, invalidates entries from the branch-resolution stage, replacing by first-invalid-then-PLRU.

Parameters:
INDEX_BITS, 3, set index width; SETS = 2**INDEX_BITS; index = pc[INDEX_BITS:1]
TAG_BITS, 12, tag width = 16 - INDEX_BITS - 1; tag = pc[15:INDEX_BITS+1]

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
lookup_pc  input  16  fetch PC (lc3b_word)
lookup_valid  input  1  lookup is real this cycle (gates LRU touch only)
comp0_out..comp3_out  output  1 each  way n valid and tag == lookup tag
target0..target3  output  16 each  stored target of way n, selected set
hit  output  1  OR of comp0..3
upd_valid  input  1  resolved branch present this cycle
upd_pc  input  16  PC of resolved branch
upd_taken  input  1  branch was taken
upd_target  input  16  resolved target
flush  input  1  synchronous clear of all entries

Behaviour:
- Reset (async, immediate): all valid bits 0, all PLRU bits 000; tags/targets need no reset. Therefore comp0..3=0, hit=0 during and after reset; targets are don't-care.
- Lookup: purely combinational read of registered state; zero-cycle latency. At most one compN is 1 (update logic never creates duplicate tags in a set). Same-cycle lookup sees pre-update contents (old state).
- PLRU bits {b2,b1,b0} per set. Victim: b0=0 -> (b1=0 ? way0 : way1); b0=1 -> (b2=0 ? way2 : way3).
- Touch way w sets bits pointing away from it: w0: b0=1,b1=1; w1: b0=1,b1=0; w2: b0=0,b2=1; w3: b0=0,b2=0. The other bit is unchanged.
- Lookup touch: on clk edge when lookup_valid & hit, touch the hitting way in the lookup set.
- Update, evaluated on the clk edge when upd_valid=1:
  - Tag matches valid way w, upd_taken=1: target[w] <= upd_target; touch w.
  - Tag matches valid way w, upd_taken=0: valid[w] <= 0; no PLRU change.
  - No match, upd_taken=1: allocate the lowest-numbered invalid way. If none is invalid, allocate the PLRU victim. Write valid=1, tag, and target, then touch the allocated way.
  - No match, upd_taken=0: no state change.
- Simultaneous lookup touch and update touch to the same set: the update's touch is applied and the lookup touch is dropped. Different sets: both are applied in the same cycle.
- flush: on clk edge, clear all valid bits and PLRU bits. It overrides any update and lookup touch that cycle.
- Reset asserted mid-update: the update is lost and all state is cleared; no partial write is permitted.
- Index/tag slicing is fixed by the parameters; pc[0] is ignored (word-aligned).

Test Plan:
- Reset then lookup_pc=0x1234 -> comp0..3=0, hit=0.
- upd_valid, upd_pc=0x1234, taken, target=0x2000 (set 2, tag 0x123) -> next cycle lookup 0x1234: comp0=1, target0=0x2000, hit=1; set 2 PLRU = b0=1,b1=1.
- Fill set 2 with tags 0x123,0x223,0x323,0x423 (pcs 0x1234,0x2234,0x3234,0x4234), then lookup 0x1234 with lookup_valid -> a 5th taken update at 0x5234 replaces way2 (b0=1,b2=0). 0x1234 still hits way0.
- Re-update 0x1234 taken with target 0x3000 -> way0 target becomes 0x3000 and no other way changes. Then update 0x1234 not-taken -> comp0=0 on next lookup.
- Same cycle: lookup 0x2234 (hit way1) and taken update at 0x1234 (hit way0). Lookup returns old target; the update's touch (way0) wins the PLRU.
- flush with a simultaneous taken update -> all lookups miss afterwards. Async reset pulse between clock edges -> hit drops to 0 immediately.
